// File: rtl/jtroc_arb_pkg.sv
// Shared types and helpers for the jtroc SDRAM ROM arbiter.
package jtroc_arb_pkg;

  localparam int unsigned NREQ = 4;

  localparam logic [1:0] MAIN = 2'd0;
  localparam logic [1:0] SND  = 2'd1;
  localparam logic [1:0] SCR  = 2'd2;
  localparam logic [1:0] OBJ  = 2'd3;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} arb_state_t;

  // Round-robin search starting at ptr; result is {found, index}.
  function automatic logic [2:0] rr_pick(input logic [NREQ-1:0] miss, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = ptr + 2'(i);
      if (!res[2] && miss[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/jtroc_arb_cache.sv
// One-word read cache for a single ROM requester: valid/tag/data, hit and
// the registered data-valid flag.
module jtroc_arb_cache
  import jtroc_arb_pkg::*;
#(
  parameter int AW = 22,
  parameter int DW = 16
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          downloading,
  input  logic          req,
  input  logic [AW-1:0] addr,
  input  logic          fill,
  input  logic [AW-1:0] fill_addr,
  input  logic [DW-1:0] fill_data,
  output logic          hit,
  output logic          ok,
  output logic [DW-1:0] data
);

  logic          valid;
  logic [AW-1:0] tag;

  assign hit = req & valid & (tag == addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
      ok    <= 1'b0;
    end else begin
      ok <= hit & ~downloading;
      // A fill that lands during a download stores the word but stays invalid.
      if (fill) begin
        tag   <= fill_addr;
        data  <= fill_data;
        valid <= ~downloading;
      end else if (downloading) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/jtroc_sdram_arb.sv
// Four-way SDRAM ROM read arbiter with one cached word per requester.
// Optional build macro JTROC_ARB_MAINPRIO_EN gives the main CPU fixed priority.
module jtroc_sdram_arb
  import jtroc_arb_pkg::*;
#(
  parameter int AW = 22,
  parameter int DW = 16
) (
  input  logic              rst,
  input  logic              clk,
  input  logic              downloading,
  input  logic [3:0]        req,
  input  logic [4*AW-1:0]   addr,
  output logic [3:0]        ok,
  output logic [4*DW-1:0]   data,
  output logic              sdram_req,
  output logic [AW-1:0]     sdram_addr,
  input  logic              sdram_ack,
  input  logic              sdram_rdy,
  input  logic [DW-1:0]     sdram_din
);

  arb_state_t      state, state_nx;
  logic [1:0]      winner, ptr, pick;
  logic [2:0]      sel;
  logic            found, grant, fill;
  logic [NREQ-1:0] hit, miss;
  logic [AW-1:0]   addr_a [NREQ];

  assign miss = req & ~hit;

`ifdef JTROC_ARB_MAINPRIO_EN
  assign sel = miss[MAIN] ? {1'b1, MAIN} : rr_pick(miss & 4'b1110, ptr);
`else
  assign sel = rr_pick(miss, ptr);
`endif
  assign found = sel[2];
  assign pick  = sel[1:0];

  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    fill     = 1'b0;
    case (state)
      IDLE: if (found && !downloading) begin
        grant    = 1'b1;
        state_nx = REQ;
      end
      REQ:  if (sdram_ack) state_nx = WAIT;
      WAIT: if (sdram_rdy) begin
        fill     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      winner     <= '0;
      ptr        <= '0;
      sdram_addr <= '0;
    end else begin
      state <= state_nx;
      if (grant) begin
        winner     <= pick;
        sdram_addr <= addr_a[pick];
`ifdef JTROC_ARB_MAINPRIO_EN
        if (pick != MAIN) ptr <= pick + 2'd1;
`else
        ptr <= pick + 2'd1;
`endif
      end
    end
  end

  assign sdram_req = (state == REQ);

  for (genvar n = 0; n < NREQ; n++) begin : g_cache
    assign addr_a[n] = addr[n*AW +: AW];

    jtroc_arb_cache #(.AW(AW), .DW(DW)) u_cache (
      .rst         (rst),
      .clk         (clk),
      .downloading (downloading),
      .req         (req[n]),
      .addr        (addr_a[n]),
      .fill        (fill && (winner == 2'(n))),
      .fill_addr   (sdram_addr),
      .fill_data   (sdram_din),
      .hit         (hit[n]),
      .ok          (ok[n]),
      .data        (data[n*DW +: DW])
    );
  end

endmodule

// File: tb/tb_jtroc_sdram_arb.sv
// Directed bench for jtroc_sdram_arb: vector tables plus grant-order sequences.
module tb_jtroc_sdram_arb;

  localparam int AW = 22;
  localparam int DW = 16;
  localparam logic [AW-1:0] Z = '0;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  dl = 1'b0;
  logic [3:0]            req = '0;
  logic [3:0][AW-1:0]    a = '0;
  logic [3:0]            ok;
  logic [4*DW-1:0]       data;
  logic                  sreq;
  logic [AW-1:0]         saddr;
  logic                  ack = 1'b0;
  logic                  rdy = 1'b0;
  logic [DW-1:0]         din = '0;

  always #5 clk = ~clk;

  jtroc_sdram_arb #(.AW(AW), .DW(DW)) dut (
    .rst         (rst),
    .clk         (clk),
    .downloading (dl),
    .req         (req),
    .addr        (a),
    .ok          (ok),
    .data        (data),
    .sdram_req   (sreq),
    .sdram_addr  (saddr),
    .sdram_ack   (ack),
    .sdram_rdy   (rdy),
    .sdram_din   (din)
  );

  typedef struct {
    string              nm;
    logic [3:0]         req;
    logic [3:0][AW-1:0] a;
    logic               dl, ack, rdy;
    logic [DW-1:0]      din;
    logic [3:0]         e_ok;
    logic               e_sreq;
    logic [AW-1:0]      e_saddr;
    logic [4*DW-1:0]    e_data;
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   nmis = 0;
  int   gnt[8];
  int   gcnt;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic add(input string nm, input logic [3:0] rq, input logic [3:0][AW-1:0] aa,
                     input logic d, input logic ak, input logic rd, input logic [DW-1:0] dn,
                     input logic [3:0] eo, input logic es, input logic [AW-1:0] ea,
                     input logic [4*DW-1:0] ed);
    vec_t v;
    v.nm = nm; v.req = rq; v.a = aa; v.dl = d; v.ack = ak; v.rdy = rd; v.din = dn;
    v.e_ok = eo; v.e_sreq = es; v.e_saddr = ea; v.e_data = ed;
    tbl.push_back(v);
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) begin
      req = tbl[i].req; a = tbl[i].a; dl = tbl[i].dl;
      ack = tbl[i].ack; rdy = tbl[i].rdy; din = tbl[i].din;
      @(posedge clk); #1;
      chk(tbl[i].nm, {ok, sreq, saddr, data},
          {tbl[i].e_ok, tbl[i].e_sreq, tbl[i].e_saddr, tbl[i].e_data});
    end
    tbl.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; a = '0; dl = 1'b0; ack = 1'b0; rdy = 1'b0; din = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Requester index is encoded in address bits [21:16] as index+1.
  task automatic grab(input int n, input int swap_at);
    gcnt = 0;
    for (int cyc = 0; cyc < 100 && gcnt < n; cyc++) begin
      @(posedge clk); #1;
      if (sreq) begin
        gnt[gcnt] = int'(saddr[21:16]) - 1;
        gcnt++;
        if (gcnt == swap_at) a[0] = 22'h010ABC;
      end
    end
    chk("grant_count", 128'(gcnt), 128'(n));
  endtask

  initial begin
    int exp6[3];

    // Reset held with every requester asking
    rst = 1'b1; req = 4'hF;
    a = {22'h040000, 22'h030000, 22'h020000, 22'h010000};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_hold", {ok, sreq}, 5'b0);
    end
    rst = 1'b0;
    chk("rst_release", {ok, sreq}, 5'b0);
    @(posedge clk); #1;
    chk("rst_first_grant", {sreq, saddr}, {1'b1, 22'h010000});
    #2 rst = 1'b1;
    #1 chk("rst_async_mid", {ok, sreq, saddr}, 27'b0);
    @(posedge clk); #1;

    // Miss then hit, immediate ack/rdy
    do_reset();
    add("t2_req",   4'b0010, {Z, Z, 22'h1234, Z}, 0, 1, 1, 16'hBEEF, 4'b0000, 1, 22'h1234, 64'h0);
    add("t2_wait",  4'b0010, {Z, Z, 22'h1234, Z}, 0, 1, 1, 16'hBEEF, 4'b0000, 0, 22'h1234, 64'h0);
    add("t2_fill",  4'b0010, {Z, Z, 22'h1234, Z}, 0, 1, 1, 16'hBEEF, 4'b0000, 0, 22'h1234, 64'h0000_0000_BEEF_0000);
    add("t2_ok",    4'b0010, {Z, Z, 22'h1234, Z}, 0, 1, 1, 16'hBEEF, 4'b0010, 0, 22'h1234, 64'h0000_0000_BEEF_0000);
    add("t2_drop",  4'b0000, {Z, Z, 22'h1234, Z}, 0, 1, 1, 16'hBEEF, 4'b0000, 0, 22'h1234, 64'h0000_0000_BEEF_0000);
    add("t2_rehit", 4'b0010, {Z, Z, 22'h1234, Z}, 0, 1, 1, 16'hBEEF, 4'b0010, 0, 22'h1234, 64'h0000_0000_BEEF_0000);
    run_tbl();

    // Round-robin, then requester 0 re-misses while 2 is still pending
    do_reset();
    req = 4'hF; ack = 1'b1; rdy = 1'b1; din = 16'h5A5A;
    a = {22'h040000, 22'h030000, 22'h020000, 22'h010000};
    grab(5, 2);
    for (int i = 0; i < 5; i++) chk($sformatf("rr_order%0d", i), 128'(gnt[i]), 128'(i % 4));

    // Address change while the fetch is outstanding
    do_reset();
    add("t4_req",    4'b0100, {Z, 22'h100, Z, Z}, 0, 1, 0, 16'h0000, 4'b0000, 1, 22'h100, 64'h0);
    add("t4_wait",   4'b0100, {Z, 22'h100, Z, Z}, 0, 1, 0, 16'h0000, 4'b0000, 0, 22'h100, 64'h0);
    add("t4_fill",   4'b0100, {Z, 22'h200, Z, Z}, 0, 1, 1, 16'h1111, 4'b0000, 0, 22'h100, 64'h0000_1111_0000_0000);
    add("t4_remiss", 4'b0100, {Z, 22'h200, Z, Z}, 0, 1, 1, 16'h2222, 4'b0000, 1, 22'h200, 64'h0000_1111_0000_0000);
    add("t4_wait2",  4'b0100, {Z, 22'h200, Z, Z}, 0, 1, 1, 16'h2222, 4'b0000, 0, 22'h200, 64'h0000_1111_0000_0000);
    add("t4_fill2",  4'b0100, {Z, 22'h200, Z, Z}, 0, 1, 1, 16'h2222, 4'b0000, 0, 22'h200, 64'h0000_2222_0000_0000);
    add("t4_ok",     4'b0100, {Z, 22'h200, Z, Z}, 0, 1, 1, 16'h2222, 4'b0100, 0, 22'h200, 64'h0000_2222_0000_0000);
    run_tbl();

    // Download during WAIT
    do_reset();
    add("t5_req",    4'b0010, {22'h77, Z, 22'h55, Z}, 0, 1, 1, 16'hAAAA, 4'b0000, 1, 22'h55, 64'h0);
    add("t5_wait",   4'b0010, {22'h77, Z, 22'h55, Z}, 0, 1, 1, 16'hAAAA, 4'b0000, 0, 22'h55, 64'h0);
    add("t5_fill",   4'b0010, {22'h77, Z, 22'h55, Z}, 0, 1, 1, 16'hAAAA, 4'b0000, 0, 22'h55, 64'h0000_0000_AAAA_0000);
    add("t5_ok",     4'b0010, {22'h77, Z, 22'h55, Z}, 0, 1, 1, 16'hAAAA, 4'b0010, 0, 22'h55, 64'h0000_0000_AAAA_0000);
    add("t5_req3",   4'b1010, {22'h77, Z, 22'h55, Z}, 0, 1, 0, 16'hBBBB, 4'b0010, 1, 22'h77, 64'h0000_0000_AAAA_0000);
    add("t5_wait3",  4'b1010, {22'h77, Z, 22'h55, Z}, 0, 1, 0, 16'hBBBB, 4'b0010, 0, 22'h77, 64'h0000_0000_AAAA_0000);
    add("t5_dlfill", 4'b1010, {22'h77, Z, 22'h55, Z}, 1, 1, 1, 16'hBBBB, 4'b0000, 0, 22'h77, 64'hBBBB_0000_AAAA_0000);
    add("t5_dl1",    4'b1010, {22'h77, Z, 22'h55, Z}, 1, 1, 1, 16'hBBBB, 4'b0000, 0, 22'h77, 64'hBBBB_0000_AAAA_0000);
    add("t5_dl2",    4'b1010, {22'h77, Z, 22'h55, Z}, 1, 1, 1, 16'hBBBB, 4'b0000, 0, 22'h77, 64'hBBBB_0000_AAAA_0000);
    add("t5_remiss", 4'b1010, {22'h77, Z, 22'h55, Z}, 0, 1, 1, 16'hCCCC, 4'b0000, 1, 22'h55, 64'hBBBB_0000_AAAA_0000);
    add("t5_wait4",  4'b1010, {22'h77, Z, 22'h55, Z}, 0, 1, 1, 16'hCCCC, 4'b0000, 0, 22'h55, 64'hBBBB_0000_AAAA_0000);
    add("t5_fill4",  4'b1010, {22'h77, Z, 22'h55, Z}, 0, 1, 1, 16'hCCCC, 4'b0000, 0, 22'h55, 64'hBBBB_0000_CCCC_0000);
    add("t5_next",   4'b1010, {22'h77, Z, 22'h55, Z}, 0, 1, 1, 16'hCCCC, 4'b0010, 1, 22'h77, 64'hBBBB_0000_CCCC_0000);
    run_tbl();

    // Requesters 0 and 3 miss together with the pointer at 2
    do_reset();
    req = 4'b0010; ack = 1'b1; rdy = 1'b1; din = 16'h1357;
    a = {22'h040000, 22'h030000, 22'h020000, 22'h010000};
    grab(1, -1);
    exp6[0] = 1;
`ifdef JTROC_ARB_MAINPRIO_EN
    exp6[1] = 0; exp6[2] = 3;
`else
    exp6[1] = 3; exp6[2] = 0;
`endif
    chk("prio_first", 128'(gnt[0]), 128'(exp6[0]));
    req = 4'b1011;
    grab(2, -1);
    chk("prio_second", 128'(gnt[0]), 128'(exp6[1]));
    chk("prio_third",  128'(gnt[1]), 128'(exp6[2]));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
